// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory fetch port.
//   FAULT_MISALIGN / FAULT_RANGE : bit positions inside rsp_fault
//   NOP_INSTR                    : addi x0,x0,0, returned on reset and on faults
//   read_lat_ok()                : legal READ_LAT values (1 or 2)
package imem_pkg;

  localparam int FAULT_MISALIGN = 0;
  localparam int FAULT_RANGE    = 1;
  localparam int FAULT_W        = 2;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic bit read_lat_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x XLEN instruction storage.
//   clk_i                 : clock, rising edge
//   rd_en_i / rd_addr_i   : synchronous read, rd_data_o updates only when rd_en_i=1
//   rd_data_o             : registered read data, holds between reads
//   wr_en_i / wr_addr_i / wr_data_i : synchronous write port
// Contents are never reset; they are filled through the write port.
module imem_array #(
  parameter int    XLEN      = 32,
  parameter int    DEPTH     = 256,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk_i,
  input  logic                     rd_en_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [XLEN-1:0]          rd_data_o,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [XLEN-1:0]          wr_data_i
);

  logic [XLEN-1:0] mem_q [DEPTH];

  // Holding rd_data_o when rd_en_i=0 is what keeps a stalled response stable.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/imem_fetch_port.sv
// Instruction memory with a valid/ready fetch port (PC in, instruction out).
//   clk_i, rst_ni               : clock, async active-low reset
//   req_valid_i/req_ready_o     : request handshake, req_pc_i = byte address
//   rsp_valid_o/rsp_ready_i     : response handshake
//   rsp_instr_o/rsp_pc_o        : fetched word (RESET_INSTR if faulted) and its PC
//   rsp_fault_o                 : [0] misaligned, [1] out of range
//   flush_i                     : drop every in-flight/pending response
//   load_en_i/load_addr_i/load_data_i : program-load write port
// The array is read at acceptance, so a later load never alters a fetch already
// in flight. READ_LAT=2 adds stage S1 carrying pc/fault while the array output
// register holds that fetch's data.
module imem_fetch_port
  import imem_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              DEPTH       = 256,
  parameter logic [XLEN-1:0] BASE_ADDR   = '0,
  parameter int              READ_LAT    = 1,
  parameter logic [XLEN-1:0] RESET_INSTR = XLEN'(NOP_INSTR),
  parameter string           INIT_FILE   = ""
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [XLEN-1:0]          req_pc_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [XLEN-1:0]          rsp_instr_o,
  output logic [XLEN-1:0]          rsp_pc_o,
  output logic [FAULT_W-1:0]       rsp_fault_o,
  input  logic                     flush_i,
  input  logic                     load_en_i,
  input  logic [$clog2(DEPTH)-1:0] load_addr_i,
  input  logic [XLEN-1:0]          load_data_i
);

  localparam int AW = $clog2(DEPTH);

  if (!read_lat_ok(READ_LAT)) begin : g_bad_lat
    $error("imem_fetch_port: READ_LAT must be 1 or 2");
  end

  logic [XLEN-1:0]    pc_off;
  logic [XLEN-1:0]    idx_full;
  logic [AW-1:0]      idx;
  logic [FAULT_W-1:0] fault_now;
  logic               out_adv;
  logic               entry_free;
  logic               accept;
  logic               rd_en;
  logic [XLEN-1:0]    rd_data;

  logic               out_valid_q;
  logic [XLEN-1:0]    out_pc_q;
  logic [FAULT_W-1:0] out_fault_q;

  // Offset is modulo 2^XLEN: a PC below BASE_ADDR becomes a huge index and
  // therefore an out-of-range fault rather than wrapping into the array.
  assign pc_off   = req_pc_i - BASE_ADDR;
  assign idx_full = pc_off >> 2;
  assign idx      = idx_full[AW-1:0];

  always_comb begin
    fault_now                 = '0;
    fault_now[FAULT_MISALIGN] = |req_pc_i[1:0];
    fault_now[FAULT_RANGE]    = (idx_full >= XLEN'(DEPTH));
  end

  assign out_adv     = !out_valid_q || rsp_ready_i;
  assign req_ready_o = !load_en_i && !flush_i && entry_free;
  assign accept      = req_valid_i && req_ready_o;
  assign rd_en       = accept && (fault_now == '0);

  imem_array #(
    .XLEN      (XLEN),
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk_i     (clk_i),
    .rd_en_i   (rd_en),
    .rd_addr_i (idx),
    .rd_data_o (rd_data),
    .wr_en_i   (load_en_i),
    .wr_addr_i (load_addr_i),
    .wr_data_i (load_data_i)
  );

  assign rsp_valid_o = out_valid_q;
  assign rsp_pc_o    = out_pc_q;
  assign rsp_fault_o = out_fault_q;

  if (READ_LAT == 2) begin : g_lat2
    logic               s1_valid_q;
    logic [XLEN-1:0]    s1_pc_q;
    logic [FAULT_W-1:0] s1_fault_q;
    logic [XLEN-1:0]    out_instr_q;

    assign entry_free = !s1_valid_q || out_adv;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        s1_valid_q <= 1'b0;
        s1_pc_q    <= '0;
        s1_fault_q <= '0;
      end else if (flush_i) begin
        s1_valid_q <= 1'b0;
      end else if (entry_free) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_pc_q    <= req_pc_i;
          s1_fault_q <= fault_now;
        end
      end
    end

    // rd_data belongs to the S1 entry: it was read when that entry was accepted
    // and no new read happens until S1 moves on.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        out_valid_q <= 1'b0;
        out_pc_q    <= '0;
        out_fault_q <= '0;
        out_instr_q <= RESET_INSTR;
      end else if (flush_i) begin
        out_valid_q <= 1'b0;
      end else if (out_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_pc_q    <= s1_pc_q;
          out_fault_q <= s1_fault_q;
          out_instr_q <= (s1_fault_q != '0) ? RESET_INSTR : rd_data;
        end
      end
    end

    assign rsp_instr_o = out_instr_q;
  end else begin : g_lat1
    assign entry_free = out_adv;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        out_valid_q <= 1'b0;
        out_pc_q    <= '0;
        out_fault_q <= '0;
      end else if (flush_i) begin
        out_valid_q <= 1'b0;
      end else if (out_adv) begin
        out_valid_q <= accept;
        if (accept) begin
          out_pc_q    <= req_pc_i;
          out_fault_q <= fault_now;
        end
      end
    end

    // The array output register is the data half of the output slot; it is
    // undefined until the first good read, hence the mux.
    assign rsp_instr_o = (out_valid_q && (out_fault_q == '0)) ? rd_data : RESET_INSTR;
  end

endmodule
